sobel_window_3x3: RTL and testbench

- Consumes the raster pixel stream and reads back the two previous image lines from internal line RAMs.
- Assembles a 3x3 neighbourhood per accepted pixel and presents it to the Sobel kernel over a valid/ready handshake.
- Sits between the pixel source and the gradient computation.
- Is the read-side counterpart to the line delay buffers: it writes each line and reads it back one and two lines later as window taps.

---
 rtl/sobel_window_3x3.sv | 107 ++++++++++
 tb/tb_sobel_window_3x3.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_3x3.sv
// rtl/sobel_window_3x3.sv - 3x3 neighbourhood builder with two line RAMs for a Sobel kernel
module sobel_window_3x3 #(
    parameter int WIDTH_P        = 8,
    parameter int LINE_WIDTH_P   = 640,
    parameter int FRAME_HEIGHT_P = 480
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [WIDTH_P-1:0]   data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [9*WIDTH_P-1:0] window_o,
    output logic                 valid_o,
    input  logic                 ready_i
);
    localparam int CW = $clog2(LINE_WIDTH_P);
    localparam int RW = $clog2(FRAME_HEIGHT_P);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH_P - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT_P - 1);

    // Line A holds the previous line, line B the one before it.
    logic [WIDTH_P-1:0] line_a_mem [LINE_WIDTH_P];
    logic [WIDTH_P-1:0] line_b_mem [LINE_WIDTH_P];
    logic [WIDTH_P-1:0] rd_a_q, rd_b_q;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic               s1_valid_q;
    logic [WIDTH_P-1:0] s1_pix_q;
    logic [CW-1:0]      s1_col_q;
    logic [RW-1:0]      s1_row_q;

    logic [9*WIDTH_P-1:0] win_q, win_d;
    logic                 valid_q;
    logic                 en;
    logic                 accept;
    logic                 win_ok;

    assign en       = ~valid_q | ready_i;
    assign ready_o  = en;
    assign accept   = valid_i & en;
    assign window_o = win_q;
    assign valid_o  = valid_q;
    assign win_ok   = (s1_col_q >= CW'(2)) && (s1_row_q >= RW'(2));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
            col_d = col_q + CW'(1);
        end
    end

    // Shift each window row left by one column and load the new right column.
    always_comb begin
        win_d = win_q;
        for (int row = 0; row < 3; row++) begin
            win_d[WIDTH_P*(3*row)   +: WIDTH_P] = win_q[WIDTH_P*(3*row+1) +: WIDTH_P];
            win_d[WIDTH_P*(3*row+1) +: WIDTH_P] = win_q[WIDTH_P*(3*row+2) +: WIDTH_P];
        end
        win_d[WIDTH_P*2 +: WIDTH_P] = rd_b_q;
        win_d[WIDTH_P*5 +: WIDTH_P] = rd_a_q;
        win_d[WIDTH_P*8 +: WIDTH_P] = s1_pix_q;
    end

    // Line RAMs are not reset; read-before-write moves A's old pixel into B.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rd_a_q            <= line_a_mem[col_q];
            rd_b_q            <= line_b_mem[col_q];
            line_a_mem[col_q] <= data_i;
            line_b_mem[col_q] <= line_a_mem[col_q];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            win_q      <= '0;
            valid_q    <= 1'b0;
        end else if (en) begin
            s1_valid_q <= valid_i;
            if (accept) begin
                col_q    <= col_d;
                row_q    <= row_d;
                s1_pix_q <= data_i;
                s1_col_q <= col_q;
                s1_row_q <= row_q;
            end
            if (s1_valid_q) begin
                win_q   <= win_d;
                valid_q <= win_ok;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb/tb_sobel_window_3x3.sv - directed bench for sobel_window_3x3 on a 4x4 frame
module tb_sobel_window_3x3;
    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [71:0] window_o;
    logic        valid_o;
    logic        ready_i = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_present_cyc = 0;
    int rdy_low_cnt = 0;
    bit mon_rdy = 1'b0;
    logic [71:0] got[$];
    int          got_cyc[$];

    sobel_window_3x3 #(.WIDTH_P(8), .LINE_WIDTH_P(4), .FRAME_HEIGHT_P(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .window_o(window_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rstn_i && valid_o && ready_i) begin
            got.push_back(window_o);
            got_cyc.push_back(cyc);
        end
        if (mon_rdy && !ready_o) rdy_low_cnt++;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] win(input int base, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[8*(3*i+j) +: 8] = 8'(base + 4*(r-2+i) + (c-2+j));
        return w;
    endfunction

    task automatic do_reset();
        @(posedge clk_i); #1;
        rstn_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        got.delete();
        got_cyc.delete();
    endtask

    task automatic push(input int p);
        bit ok;
        int guard;
        guard = 0;
        data_i = 8'(p);
        valid_i = 1'b1;
        do begin
            @(negedge clk_i);
            ok = ready_o;
            last_present_cyc = cyc;
            @(posedge clk_i); #1;
            guard++;
        end while (!ok && guard < 200);
        if (!ok) chk("push_timeout", 72'(guard), 72'(0));
        valid_i = 1'b0;
    endtask

    task automatic push_frame(input int base);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                push(base + 4*r + c);
    endtask

    task automatic drain();
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_frame(input string tag, input int base, input int first_idx);
        for (int k = 0; k < 4; k++)
            if (first_idx + k < got.size())
                chk(tag, got[first_idx+k], win(base, 2 + k/2, 2 + k%2));
    endtask

    logic [71:0] first_win;
    logic [71:0] second_win;
    logic [71:0] last_win;
    int acc10;

    initial begin
        first_win  = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        second_win = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
        last_win   = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};

        // reset state
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 72'(valid_o), 72'(0));
        chk("rst_window", window_o, 72'(0));
        chk("rst_ready", 72'(ready_o), 72'(1));
        do_reset();
        chk("post_rst_ready", 72'(ready_o), 72'(1));

        // continuous single frame
        mon_rdy = 1'b1;
        for (int p = 0; p < 16; p++) begin
            push(p);
            if (p == 10) acc10 = last_present_cyc;
        end
        mon_rdy = 1'b0;
        drain();
        chk("f1_count", 72'(got.size()), 72'(4));
        chk("ready_always_high", 72'(rdy_low_cnt), 72'(0));
        if (got.size() == 4) begin
            chk("f1_first", got[0], first_win);
            chk("f1_last", got[3], last_win);
            chk("f1_latency", 72'(got_cyc[0] - acc10), 72'(2));
            chk("f1_consec_row2", 72'(got_cyc[1] - got_cyc[0]), 72'(1));
            chk("f1_consec_row3", 72'(got_cyc[3] - got_cyc[2]), 72'(1));
        end
        chk_frame("f1_win", 0, 0);

        // backpressure for 5 cycles on the first window
        do_reset();
        fork
            push_frame(0);
            begin : stall
                int g;
                g = 0;
                while (!valid_o && g < 100) begin
                    @(posedge clk_i); #1;
                    g++;
                end
                ready_i = 1'b0;
                repeat (5) begin
                    @(negedge clk_i);
                    chk("stall_ready_o", 72'(ready_o), 72'(0));
                    chk("stall_window", window_o, first_win);
                    @(posedge clk_i); #1;
                end
                ready_i = 1'b1;
            end
        join
        drain();
        chk("stall_count", 72'(got.size()), 72'(4));
        if (got.size() >= 2) chk("stall_next", got[1], second_win);
        chk_frame("stall_win", 0, 0);

        // two back-to-back frames
        do_reset();
        push_frame(0);
        push_frame(100);
        drain();
        chk("ff_count", 72'(got.size()), 72'(8));
        if (got.size() == 8)
            chk("ff_first2", got[4],
                {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});
        chk_frame("ff_win0", 0, 0);
        chk_frame("ff_win1", 100, 4);

        // random input gaps
        do_reset();
        for (int p = 0; p < 16; p++) begin
            repeat ($urandom_range(0, 1)) @(posedge clk_i);
            #1;
            push(p);
        end
        drain();
        chk("gap_count", 72'(got.size()), 72'(4));
        chk_frame("gap_win", 0, 0);

        // reset mid-frame after pixel 9
        do_reset();
        for (int p = 0; p < 10; p++) push(p);
        rstn_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_valid", 72'(valid_o), 72'(0));
        chk("midrst_window", window_o, 72'(0));
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        got.delete();
        got_cyc.delete();
        push_frame(0);
        drain();
        chk("midrst_count", 72'(got.size()), 72'(4));
        if (got.size() >= 1) chk("midrst_first", got[0], first_win);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1);
    end
endmodule
